// File: rtl/key_move_ctrl_if.sv
// Key-frame input and move-handshake output bundle for key_move_ctrl.
// Signal names match the original flat ports.
interface key_move_ctrl_if;
   logic       scan_ready;
   logic [7:0] scan_code1;
   logic [7:0] scan_code2;
   logic [7:0] scan_code3;
   logic       move_ack;
   logic [5:0] move_from;
   logic [5:0] move_to;
   logic       move_valid;
   logic [2:0] entry_stage;
   logic       key_error;

   modport master (
      output scan_ready, scan_code1, scan_code2, scan_code3, move_ack,
      input  move_from, move_to, move_valid, entry_stage, key_error
   );

   modport slave (
      input  scan_ready, scan_code1, scan_code2, scan_code3, move_ack,
      output move_from, move_to, move_valid, entry_stage, key_error
   );
endinterface

// File: rtl/key_move_ctrl.sv
// Turns validated PS/2 key frames into a chess move (from/to squares) and
// presents it on a valid/ack handshake.
module key_move_ctrl #(
   parameter bit CONFIRM_REQUIRED = 1'b1
) (
   input  logic             clk50,
   input  logic             reset,
   key_move_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      S_FF    = 3'd0,
      S_FR    = 3'd1,
      S_TF    = 3'd2,
      S_TR    = 3'd3,
      S_CONF  = 3'd4,
      S_ISSUE = 3'd5
   } state_t;

   state_t     state;
   logic       sr_q;
   logic       armed;
   logic [2:0] from_file, from_rank, to_file, to_rank;
   logic       move_valid_q, key_error_q;

   logic       key_event, frame_ok;
   logic       is_file, is_rank, is_enter, is_bksp, is_esc;
   logic [2:0] key_val;

   // armed blocks a frame still in flight at reset release: a rise only
   // counts once scan_ready has been sampled low after reset.
   assign key_event = bus.scan_ready && !sr_q && armed;
   assign frame_ok  = (bus.scan_code2 == 8'hF0) && (bus.scan_code1 == bus.scan_code3);
   assign is_enter  = (bus.scan_code1 == 8'h5A);
   assign is_bksp   = (bus.scan_code1 == 8'h66);
   assign is_esc    = (bus.scan_code1 == 8'h76);

   always_comb begin
      is_file = 1'b0;
      is_rank = 1'b0;
      key_val = '0;
      case (bus.scan_code1)
         8'h1C: begin is_file = 1'b1; key_val = 3'd0; end
         8'h32: begin is_file = 1'b1; key_val = 3'd1; end
         8'h21: begin is_file = 1'b1; key_val = 3'd2; end
         8'h23: begin is_file = 1'b1; key_val = 3'd3; end
         8'h24: begin is_file = 1'b1; key_val = 3'd4; end
         8'h2B: begin is_file = 1'b1; key_val = 3'd5; end
         8'h34: begin is_file = 1'b1; key_val = 3'd6; end
         8'h33: begin is_file = 1'b1; key_val = 3'd7; end
         8'h16: begin is_rank = 1'b1; key_val = 3'd0; end
         8'h1E: begin is_rank = 1'b1; key_val = 3'd1; end
         8'h26: begin is_rank = 1'b1; key_val = 3'd2; end
         8'h25: begin is_rank = 1'b1; key_val = 3'd3; end
         8'h2E: begin is_rank = 1'b1; key_val = 3'd4; end
         8'h36: begin is_rank = 1'b1; key_val = 3'd5; end
         8'h3D: begin is_rank = 1'b1; key_val = 3'd6; end
         8'h3E: begin is_rank = 1'b1; key_val = 3'd7; end
         default: ;
      endcase
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         state        <= S_FF;
         sr_q         <= 1'b0;
         armed        <= 1'b0;
         from_file    <= '0;
         from_rank    <= '0;
         to_file      <= '0;
         to_rank      <= '0;
         move_valid_q <= 1'b0;
         key_error_q  <= 1'b0;
      end else begin
         sr_q        <= bus.scan_ready;
         armed       <= armed | !bus.scan_ready;
         key_error_q <= 1'b0;
         if (state == S_ISSUE) begin
            if (bus.move_ack && move_valid_q) begin
               move_valid_q <= 1'b0;
               state        <= S_FF;
            end
         end else if (key_event) begin
            if (!frame_ok) begin
               key_error_q <= 1'b1;
            end else if (is_esc) begin
               state <= S_FF;
            end else if (is_bksp) begin
               case (state)
                  S_FR:    state <= S_FF;
                  S_TF:    state <= S_FR;
                  S_TR:    state <= S_TF;
                  S_CONF:  state <= S_TR;
                  default: ;
               endcase
            end else begin
               case (state)
                  S_FF:
                     if (is_file) begin
                        from_file <= key_val;
                        state     <= S_FR;
                     end else key_error_q <= 1'b1;
                  S_FR:
                     if (is_rank) begin
                        from_rank <= key_val;
                        state     <= S_TF;
                     end else key_error_q <= 1'b1;
                  S_TF:
                     if (is_file) begin
                        to_file <= key_val;
                        state   <= S_TR;
                     end else key_error_q <= 1'b1;
                  S_TR:
                     if (is_rank) begin
                        to_rank <= key_val;
                        // Without confirmation the compare uses the incoming rank directly.
                        if (CONFIRM_REQUIRED) begin
                           state <= S_CONF;
                        end else if ({from_rank, from_file} == {key_val, to_file}) begin
                           key_error_q <= 1'b1;
                           state       <= S_TF;
                        end else begin
                           move_valid_q <= 1'b1;
                           state        <= S_ISSUE;
                        end
                     end else key_error_q <= 1'b1;
                  S_CONF:
                     if (is_enter) begin
                        if ({from_rank, from_file} == {to_rank, to_file}) begin
                           key_error_q <= 1'b1;
                           state       <= S_TF;
                        end else begin
                           move_valid_q <= 1'b1;
                           state        <= S_ISSUE;
                        end
                     end else key_error_q <= 1'b1;
                  default: state <= S_FF;
               endcase
            end
         end
      end
   end

   assign bus.move_from   = {from_rank, from_file};
   assign bus.move_to     = {to_rank, to_file};
   assign bus.move_valid  = move_valid_q;
   assign bus.key_error   = key_error_q;
   assign bus.entry_stage = state;

endmodule
